// File: rtl/seq_divider.sv
// seq_divider: iterative signed restoring divider, one quotient bit per clock.
// Define DIV_REMAINDER_EN to expose the signed remainder on data_remainder.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mag_b, rem, quot;
    logic sign_q, div0, ovf;
`ifdef DIV_REMAINDER_EN
    logic sign_r;
`endif
    logic [WIDTH:0] sh, trial;
    always_comb begin
        sh = {rem, quot[WIDTH-1]};
        trial = sh - {1'b0, mag_b};
    end
    // quot starts holding |A| so dividend bits shift out as quotient bits shift in
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            mag_b <= '0;
            rem <= '0;
            quot <= '0;
            sign_q <= 1'b0;
            div0 <= 1'b0;
            ovf <= 1'b0;
            data_result <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sign_r <= 1'b0;
            data_remainder <= '0;
`endif
        end else if (ctrl_div) begin
            state <= BUSY;
            cnt <= '0;
            rem <= '0;
            quot <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            mag_b <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0 <= data_operandB == '0;
            ovf <= data_operandA == MIN && data_operandB == '1;
            data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sign_r <= data_operandA[WIDTH-1];
`endif
        end else begin
            case (state)
                BUSY: begin
                    rem <= trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
                end
                FIXUP: begin
                    data_result <= div0 ? '0 : ovf ? MIN : sign_q ? -quot : quot;
                    data_exception <= div0 | ovf;
                    data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
                    data_remainder <= (div0 | ovf) ? '0 : sign_r ? -rem : rem;
`endif
                    state <= DONE;
                end
                DONE: begin
                    data_resultRDY <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider at WIDTH=32.
module tb_seq_divider;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic ctrl_div = 1'b0;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic [31:0] data_result;
    logic data_exception, data_resultRDY;
    int n_cmp = 0, n_bad = 0;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif
    seq_divider #(.WIDTH(32)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ctrl_div(ctrl_div),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .data_result(data_result),
`ifdef DIV_REMAINDER_EN
        .data_remainder(data_remainder),
`endif
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_div = 1'b1;
        @(posedge clock);
        #1 ctrl_div = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic e, input logic [31:0] m);
        int lat;
        start(a, b);
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
        wait_rdy(lat);
        check({tag, "_lat"}, lat, 33);
        check({tag, "_res"}, data_result, r);
        check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, e});
`ifdef DIV_REMAINDER_EN
        check({tag, "_rem"}, data_remainder, m);
`else
        if (m === 32'hx) $display("unreachable");
`endif
        @(posedge clock);
        #1 check({tag, "_rdy_drop"}, {31'b0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int lat, pulses;
        #12;
        check("rst_res", data_result, 0);
        check("rst_exc", {31'b0, data_exception}, 0);
        check("rst_rdy", {31'b0, data_resultRDY}, 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        run_op("p100_7", 100, 7, 14, 0, 2);
        run_op("n100_7", -32'sd100, 7, 32'hFFFF_FFF2, 0, 32'hFFFF_FFFE);
        run_op("p7_n100", 7, -32'sd100, 0, 0, 7);
        run_op("n100_n7", -32'sd100, -32'sd7, 14, 0, 32'hFFFF_FFFE);
        run_op("div0", 5, 0, 0, 1, 0);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("min_1", 32'h8000_0000, 1, 32'h8000_0000, 0, 0);
        run_op("max_2", 32'h7FFF_FFFF, 2, 32'h3FFF_FFFF, 0, 1);
        run_op("min_n7", 32'h8000_0000, -32'sd7, 32'h1249_2492, 0, 32'hFFFF_FFFE);
        run_op("p9_3", 9, 3, 3, 0, 0);
        run_op("p100_7b", 100, 7, 14, 0, 2);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            data_operandA = $urandom;
            data_operandB = $urandom;
            @(posedge clock);
            #1 pulses += int'(data_resultRDY);
        end
        check("hold_rdy", pulses, 0);
        check("hold_res", data_result, 14);
        check("hold_exc", {31'b0, data_exception}, 0);
        start(100, 7);
        for (int i = 1; i < 10; i++) begin
            @(posedge clock);
            #1;
        end
        start(9, 3);
        wait_rdy(lat);
        check("restart_lat", lat, 33);
        check("restart_res", data_result, 3);
        @(posedge clock);
        #1 check("restart_drop", {31'b0, data_resultRDY}, 0);
        data_operandA = 100;
        data_operandB = 7;
        ctrl_div = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1 pulses += int'(data_resultRDY);
        end
        ctrl_div = 1'b0;
        check("held_rdy", pulses, 0);
        check("held_res", data_result, 3);
        start(100, 7);
        for (int i = 1; i < 15; i++) begin
            @(posedge clock);
            #1;
        end
        #2 reset_n = 1'b0;
        #1;
        check("arst_res", data_result, 0);
        check("arst_exc", {31'b0, data_exception}, 0);
        check("arst_rdy", {31'b0, data_resultRDY}, 0);
        @(negedge clock) reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1 pulses += int'(data_resultRDY);
        end
        check("arst_norpy", pulses, 0);
        run_op("post_rst", -32'sd9, 3, 32'hFFFF_FFFD, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
